// File: rtl/pipe_pkg.sv
// Shared encodings for the elastic pipeline stage register: occupancy states,
// the RISC-V NOP used as a bubble, and per-stage field indices.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } pipe_state_e;

  localparam logic [31:0] RV_NOP = 32'h0000_0013;  // addi x0,x0,0

  // IF/ID
  localparam int IFID_CTRL    = 0;
  localparam int IFID_PC_ADDR = 1;
  localparam int IFID_PC_NEXT = 2;
  localparam int IFID_INSTR   = 3;

  // ID/EX
  localparam int IDEX_CTRL    = 0;
  localparam int IDEX_PC_ADDR = 1;
  localparam int IDEX_DATA1   = 2;
  localparam int IDEX_DATA2   = 3;
  localparam int IDEX_IMM     = 4;
  localparam int IDEX_INSTR   = 5;

  // EX/MEM
  localparam int EXMEM_CTRL    = 0;
  localparam int EXMEM_PC_ADDR = 1;
  localparam int EXMEM_PC_NEXT = 2;
  localparam int EXMEM_ALU     = 3;
  localparam int EXMEM_DATA2   = 4;
  localparam int EXMEM_INSTR   = 5;

  // MEM/WB
  localparam int MEMWB_CTRL    = 0;
  localparam int MEMWB_ALU     = 1;
  localparam int MEMWB_RDATA   = 2;
  localparam int MEMWB_INSTR   = 3;

endpackage

// File: rtl/pipe_slot.sv
// One storage slot of the stage register: a data word that loads on demand and
// a valid flop with set/clear (clear wins). Both reset asynchronously to 0.
module pipe_slot #(
  parameter int W = 192
) (
  input  logic         clk,
  input  logic         i_rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_d,
  input  logic         i_set,
  input  logic         i_clr,
  output logic [W-1:0] o_q,
  output logic         o_valid
);

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_q     <= '0;
      o_valid <= 1'b0;
    end else begin
      if (i_load) o_q <= i_d;
      if (i_clr)       o_valid <= 1'b0;
      else if (i_set)  o_valid <= 1'b1;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic two-entry pipeline stage register (main slot + skid slot) with
// registered back-pressure and synchronous flush. Optional bubble output on
// invalid cycles is enabled by defining PIPE_STAGE_BUBBLE_EN.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_FIELDS  = 6,
  parameter int CTRL_FIELD  = 0,
  parameter int INSTR_FIELD = 5
) (
  input  logic                             clk,
  input  logic                             i_rst_n,
  input  logic [NUM_FIELDS*DATA_WIDTH-1:0] i_data,
  input  logic                             i_valid,
  output logic                             o_ready,
  output logic [NUM_FIELDS*DATA_WIDTH-1:0] o_data,
  output logic                             o_valid,
  input  logic                             i_ready,
  input  logic                             i_flush,
  output logic [1:0]                       o_count
);

  localparam int W = NUM_FIELDS * DATA_WIDTH;

`ifdef PIPE_STAGE_BUBBLE_EN
  localparam bit BUBBLE_EN = 1'b1;
`else
  localparam bit BUBBLE_EN = 1'b0;
`endif

  // NOP in the instruction field, control field forced to zero.
  localparam logic [W-1:0] BUBBLE =
    (W'(RV_NOP[DATA_WIDTH-1:0]) << (INSTR_FIELD * DATA_WIDTH)) &
    ~(W'({DATA_WIDTH{1'b1}}) << (CTRL_FIELD * DATA_WIDTH));

  logic [W-1:0] main_q, skid_q, main_d;
  logic         main_v, skid_v;
  logic         main_ld, main_set, main_clr;
  logic         skid_ld, skid_set, skid_clr;
  logic         acc, xfer;
  pipe_state_e  state;

  assign state = skid_v ? ST_FULL : (main_v ? ST_ONE : ST_EMPTY);
  assign acc   = i_valid && o_ready;
  assign xfer  = main_v && i_ready;

  always_comb begin
    main_ld  = 1'b0;
    main_d   = i_data;
    main_set = 1'b0;
    main_clr = 1'b0;
    skid_ld  = 1'b0;
    skid_set = 1'b0;
    skid_clr = 1'b0;
    if (i_flush) begin
      // Any accept this cycle is dropped; a transfer has already happened.
      main_clr = 1'b1;
      skid_clr = 1'b1;
    end else begin
      unique case (state)
        ST_EMPTY: begin
          if (acc) begin
            main_ld  = 1'b1;
            main_set = 1'b1;
          end
        end
        ST_ONE: begin
          if (acc && xfer) begin
            main_ld  = 1'b1;
            main_set = 1'b1;
          end else if (acc) begin
            skid_ld  = 1'b1;
            skid_set = 1'b1;
          end else if (xfer) begin
            main_clr = 1'b1;
          end
        end
        ST_FULL: begin
          if (xfer) begin
            main_ld  = 1'b1;
            main_d   = skid_q;
            main_set = 1'b1;
            skid_clr = 1'b1;
          end
        end
        default: begin
          main_clr = 1'b1;
          skid_clr = 1'b1;
        end
      endcase
    end
  end

  pipe_slot #(.W(W)) u_main (
    .clk     (clk),
    .i_rst_n (i_rst_n),
    .i_load  (main_ld),
    .i_d     (main_d),
    .i_set   (main_set),
    .i_clr   (main_clr),
    .o_q     (main_q),
    .o_valid (main_v)
  );

  pipe_slot #(.W(W)) u_skid (
    .clk     (clk),
    .i_rst_n (i_rst_n),
    .i_load  (skid_ld),
    .i_d     (i_data),
    .i_set   (skid_set),
    .i_clr   (skid_clr),
    .o_q     (skid_q),
    .o_valid (skid_v)
  );

  assign o_ready = !skid_v;
  assign o_valid = main_v;
  assign o_count = {1'b0, main_v} + {1'b0, skid_v};
  assign o_data  = (BUBBLE_EN && !main_v) ? BUBBLE : main_q;

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

- Parametrised, elastic pipeline stage register carrying `NUM_FIELDS` words of `DATA_WIDTH` bits between two CPU stages (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Uses a valid/ready handshake, a two-entry skid buffer for full throughput with registered back-pressure, and a synchronous flush that squashes in-flight contents.
- Replaces the per-stage fixed-field registers; each stage instantiates it with its own field count.

## Interface
Parameters:
- `DATA_WIDTH`, 32, bits per field.
- `NUM_FIELDS`, 6, number of fields. Field k occupies bits [k*DATA_WIDTH +: DATA_WIDTH] of the packed buses.
- `CTRL_FIELD`, 0, index of the control-signal field.
- `INSTR_FIELD`, 5, index of the instruction field.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  clock, rising edge.
- `i_rst_n`  in  1  asynchronous active-low reset.
- `i_data`  in  NUM_FIELDS*DATA_WIDTH  packed upstream fields.
- `i_valid`  in  1  upstream data valid.
- `o_ready`  out  1  stage can accept.
- `o_data`  out  NUM_FIELDS*DATA_WIDTH  packed downstream fields.
- `o_valid`  out  1  downstream data valid.
- `i_ready`  in  1  downstream accepts (low = stall).
- `i_flush`  in  1  synchronous squash, e.g. on branch taken or exception.
- `o_count`  out  2  entries held (0..2).

## Operation
- Accept happens when `i_valid && o_ready`. Transfer happens when `o_valid && i_ready`.
- Storage: a main slot drives `o_data`/`o_valid`; a skid slot sits behind it.
- `o_ready = !skid_valid`. It is derived only from registers, with no combinational path from `i_ready`.
- States: EMPTY (count 0), ONE (main valid), FULL (main and skid valid).
- EMPTY:
  - accept → ONE, main ← `i_data`.
- ONE:
  - accept and transfer → ONE, main ← `i_data`.
  - accept only → FULL, skid ← `i_data`.
  - transfer only → EMPTY.
  - neither → ONE, hold.
- FULL:
  - No accept is possible.
  - transfer → ONE, main ← skid.
  - otherwise hold.
- Order is strictly FIFO; no entry is dropped or duplicated except on flush.
- Flush has highest priority:
  - Next state is EMPTY, all valids are cleared, and any accept in that cycle is discarded.
  - A transfer in the flush cycle still counts as completed, since the consumer already took it.
- Data registers load only when their slot is written. Invalid slots keep stale data unless `PIPE_STAGE_BUBBLE_EN` is defined.
- `o_count` = main_valid + skid_valid.

## Timing
- Reset (async assert, sync deassert expected upstream) gives:
  - `o_valid`=0, `o_count`=0, `o_ready`=1.
  - All `o_data` bits 0, skid data 0.
- Reset asserted mid-operation discards all contents immediately, without waiting for a clock edge.
- Latency: 1 cycle from accept in EMPTY to `o_valid`.
- Throughput: 1 word/cycle while `i_ready`=1.
- `o_ready` falls in the cycle after a stall with an accept in ONE (entering FULL). It rises the cycle after the FULL-state transfer.
- `i_flush` takes effect at the next rising edge. `o_valid`=0 and `o_ready`=1 follow that edge.

## Configuration
- Macro: `PIPE_STAGE_BUBBLE_EN`.
- Defined: whenever `o_valid`=0, `o_data` shows a bubble:
  - all fields 0, except `INSTR_FIELD` = 32'h0000_0013 (RISC-V `addi x0,x0,0`).
  - `CTRL_FIELD` is 0, so downstream control sees no writes.
  - Reset value of the `INSTR_FIELD` of `o_data` becomes 32'h0000_0013.
- Undefined: `o_data` is the raw main-slot register, and its value is don't-care while `o_valid`=0.

## Structure
- Package `pipe_pkg` holds:
  - state encodings (`ST_EMPTY`, `ST_ONE`, `ST_FULL`).
  - `RV_NOP` = 32'h0000_0013.
  - per-stage field-index constants, e.g. EX/MEM: CTRL=0, PC_ADDR=1, PC_NEXT=2, ALU=3, DATA2=4, INSTR=5.
- Sub-module `pipe_slot`: one NUM_FIELDS*DATA_WIDTH data register plus a valid flop, with load, set-valid and clear-valid inputs and async active-low clear. It is instantiated twice, as main and skid.

## Test plan
- Reset: hold `i_rst_n`=0, drive `i_valid`=1 → `o_valid`=0, `o_ready`=1, `o_count`=0, `o_data`=0 (bubble NOP in `INSTR_FIELD` if the macro is defined).
- Streaming: `i_ready`=1, push field0 = 1..8 on consecutive cycles → `o_data` field0 = 1..8, one cycle late, no gaps.
- Stall: push A, B, C with `i_ready`=0 from cycle 1 → A held on output, B in skid, `o_ready`=0 at `o_count`=2, C not accepted. Release → A, B, C emerge in order.
- Flush in FULL with simultaneous `i_valid`=1 → next cycle `o_valid`=0, `o_count`=0; the new word never appears.
- Async reset mid-stream, mid-cycle → `o_valid` falls before the next clock edge.
- Random `i_valid`/`i_ready` for 10k cycles against a reference FIFO model → no loss, duplication or reordering, and `o_ready` never depends combinationally on `i_ready`.
